// File: rtl/octal_entry_pkg.sv
// rtl/octal_entry_pkg.sv - shared types for the octal operand entry unit
package octal_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        HOLD,
        ERR
    } state_t;

    localparam int MAX_DIGITS = 3;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLEAR,
        EV_ENTER,
        EV_BACK,
        EV_DIGIT
    } event_t;

    // Only one event is acted on per cycle: clear > enter > back > digit.
    function automatic event_t select_event(
        input logic clr,
        input logic ent,
        input logic bck,
        input logic dig
    );
        if (clr) begin
            return EV_CLEAR;
        end else if (ent) begin
            return EV_ENTER;
        end else if (bck) begin
            return EV_BACK;
        end else if (dig) begin
            return EV_DIGIT;
        end
        return EV_NONE;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchronizer, debouncer and rising-edge pulse
module btn_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise_q;
    logic          rise_d;

    // The counter only advances while the synchronized level disagrees with the accepted one.
    always_comb begin
        db_d   = db_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                db_d   = sync_q[1];
                rise_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
        end
    end

    assign level_o = db_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/octal_entry_encoder.sv
// rtl/octal_entry_encoder.sv - assembles keyed octal digits into an 8-bit operand with commit handshake
module octal_entry_encoder
    import octal_entry_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_digit,
    input  logic       btn_digit,
    input  logic       btn_back,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic       commit_ready,
    output logic       commit_valid,
    output logic [7:0] commit_data,
    output logic [7:0] value,
    output logic [1:0] ndig,
    output logic       err_ovf
);

    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;

    assign btn_raw = {btn_clear, btn_enter, btn_back, btn_digit};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DB_CYCLES(DB_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .rise_o (btn_rise[i])
        );
    end

    logic [2:0] sw_s1_q;
    logic [2:0] sw_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_digit;
            sw_s2_q <= sw_s1_q;
        end
    end

    state_t     state_q, state_d;
    logic [7:0] value_q, value_d;
    logic [1:0] ndig_q, ndig_d;
    logic       err_q, err_d;
    logic       cv_q, cv_d;
    logic [7:0] cd_q, cd_d;
    event_t     ev;

    assign ev = select_event(btn_rise[3], btn_rise[2], btn_rise[1], btn_rise[0]);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        ndig_d  = ndig_q;
        err_d   = err_q;
        cv_d    = cv_q;
        cd_d    = cd_q;
        if (ev == EV_CLEAR) begin
            state_d = IDLE;
            value_d = '0;
            ndig_d  = '0;
            err_d   = 1'b0;
            cv_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ev == EV_DIGIT) begin
                        value_d = {5'b0, sw_s2_q};
                        ndig_d  = 2'd1;
                        state_d = ENTRY;
                    end
                end
                ENTRY: begin
                    unique case (ev)
                        EV_ENTER: begin
                            cv_d    = 1'b1;
                            cd_d    = value_q;
                            state_d = HOLD;
                        end
                        EV_BACK: begin
                            value_d = value_q >> 3;
                            ndig_d  = ndig_q - 2'd1;
                            if (ndig_q == 2'd1) begin
                                state_d = IDLE;
                            end
                        end
                        EV_DIGIT: begin
                            // A third digit only fits if the top octal digit is 0..3.
                            if ((ndig_q == 2'(MAX_DIGITS)) || ((ndig_q == 2'd2) && value_q[5])) begin
                                err_d   = 1'b1;
                                state_d = ERR;
                            end else begin
                                value_d = {value_q[4:0], sw_s2_q};
                                ndig_d  = ndig_q + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (commit_ready) begin
                        cv_d    = 1'b0;
                        value_d = '0;
                        ndig_d  = '0;
                        state_d = IDLE;
                    end
                end
                ERR: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            ndig_q  <= '0;
            err_q   <= 1'b0;
            cv_q    <= 1'b0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            ndig_q  <= ndig_d;
            err_q   <= err_d;
            cv_q    <= cv_d;
            cd_q    <= cd_d;
        end
    end

    assign commit_valid = cv_q;
    assign commit_data  = cd_q;
    assign value        = value_q;
    assign ndig         = ndig_q;
    assign err_ovf      = err_q;

    logic unused_levels;
    assign unused_levels = ^btn_level;

endmodule

// File: tb/tb_octal_entry_encoder.sv
// tb/tb_octal_entry_encoder.sv - scoreboard bench for octal_entry_encoder
module tb_octal_entry_encoder;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sw_digit = '0;
    logic       btn_digit = 1'b0;
    logic       btn_back = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic       commit_ready = 1'b0;
    logic       commit_valid;
    logic [7:0] commit_data;
    logic [7:0] value;
    logic [1:0] ndig;
    logic       err_ovf;

    octal_entry_encoder #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_digit    (sw_digit),
        .btn_digit   (btn_digit),
        .btn_back    (btn_back),
        .btn_enter   (btn_enter),
        .btn_clear   (btn_clear),
        .commit_ready(commit_ready),
        .commit_valid(commit_valid),
        .commit_data (commit_data),
        .value       (value),
        .ndig        (ndig),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int n;
        int e;
        int cv;
        int cd;
    } snap_t;

    snap_t snap_q[$];
    int    commit_q[$];
    int    total = 0;
    int    bad = 0;

    // Reference model: operand as an integer, digit count, error and pending-commit flags.
    int m_val = 0, m_nd = 0, m_err = 0, m_pend = 0, m_cd = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_nd = 0; m_err = 0; m_pend = 0; m_cd = 0;
    endtask

    task automatic model_transfer();
        commit_q.push_back(m_cd);
        m_pend = 0;
        m_val = 0;
        m_nd = 0;
    endtask

    task automatic model_event(input logic [3:0] m, input int d);
        if (m[3]) begin
            m_val = 0; m_nd = 0; m_err = 0; m_pend = 0;
        end else if (m_err != 0 || m_pend != 0) begin
        end else if (m[2]) begin
            if (m_nd > 0) begin
                m_pend = 1;
                m_cd = m_val;
                if (commit_ready) model_transfer();
            end
        end else if (m[1]) begin
            if (m_nd > 0) begin
                m_val = m_val / 8;
                m_nd--;
            end
        end else if (m[0]) begin
            if (m_nd == 3 || (m_nd == 2 && m_val >= 32)) begin
                m_err = 1;
            end else begin
                m_val = (m_val * 8 + d) % 256;
                m_nd++;
            end
        end
    endtask

    task automatic push_snap();
        snap_q.push_back('{m_val, m_nd, m_err, m_pend, m_cd});
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m, input logic [2:0] d);
        sw_digit = d;
        repeat (3) @(posedge clk);
        #1;
        model_event(m, int'(d));
        {btn_clear, btn_enter, btn_back, btn_digit} = m;
        repeat (DB + 6) @(posedge clk);
        #1;
        {btn_clear, btn_enter, btn_back, btn_digit} = 4'b0;
        repeat (DB + 6) @(posedge clk);
        #1;
        push_snap();
    endtask

    task automatic set_ready(input logic r);
        commit_ready = r;
        if (r && m_pend != 0) model_transfer();
        repeat (3) @(posedge clk);
        #1;
        push_snap();
    endtask

    task automatic latency_check();
        int cnt;
        sw_digit = 3'd3;
        repeat (3) @(posedge clk);
        #1;
        btn_digit = 1'b1;
        cnt = 0;
        while (ndig == 2'd0 && cnt < 50) begin
            @(posedge clk);
            cnt++;
            #1;
        end
        chk("press_latency", cnt, 3 + DB);
        btn_digit = 1'b0;
        model_event(4'b0001, 3);
        repeat (DB + 6) @(posedge clk);
        #1;
        push_snap();
    endtask

    // Monitor: checks queued snapshots and every accepted commit.
    always @(negedge clk) begin
        if (!rst) begin
            if (snap_q.size() > 0) begin
                snap_t s;
                s = snap_q.pop_front();
                chk("value", int'(value), s.v);
                chk("ndig", int'(ndig), s.n);
                chk("err_ovf", int'(err_ovf), s.e);
                chk("commit_valid", int'(commit_valid), s.cv);
                if (s.cv != 0) chk("held_commit_data", int'(commit_data), s.cd);
            end
            if (commit_valid && commit_ready) begin
                if (commit_q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    chk("commit_data", int'(commit_data), commit_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", int'(value), 0);
        chk("rst_ndig", int'(ndig), 0);
        chk("rst_commit_valid", int'(commit_valid), 0);
        chk("rst_commit_data", int'(commit_data), 0);
        chk("rst_err_ovf", int'(err_ovf), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        commit_ready = 1'b1;
        press(4'b0001, 3'd3);
        press(4'b0001, 3'd7);
        press(4'b0001, 3'd7);
        press(4'b0100, 3'd0);

        commit_ready = 1'b0;
        press(4'b0001, 3'd4);
        press(4'b0001, 3'd0);
        press(4'b0001, 3'd0);
        press(4'b0100, 3'd0);
        press(4'b1000, 3'd0);

        press(4'b0001, 3'd1);
        press(4'b0001, 3'd2);
        press(4'b0010, 3'd0);
        press(4'b0010, 3'd0);
        press(4'b0010, 3'd0);

        press(4'b0001, 3'd5);
        press(4'b0100, 3'd0);
        for (int i = 0; i < 3; i++) press(4'b0001, 3'(i + 1));
        set_ready(1'b1);
        commit_ready = 1'b0;

        // Glitch one cycle shorter than the debounce window.
        press(4'b0001, 3'd2);
        btn_digit = 1'b1;
        repeat (DB - 1) @(posedge clk);
        #1;
        btn_digit = 1'b0;
        repeat (DB + 6) @(posedge clk);
        #1;
        push_snap();
        press(4'b1100, 3'd0);

        press(4'b0001, 3'd6);
        press(4'b0100, 3'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_hold_commit_valid", int'(commit_valid), 0);
        chk("rst_hold_value", int'(value), 0);
        chk("rst_hold_ndig", int'(ndig), 0);
        chk("rst_hold_commit_data", int'(commit_data), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        latency_check();
        press(4'b1000, 3'd0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) press(4'b0001, 3'($urandom_range(0, 7)));
            else if (r == 5) press(4'b0010, 3'd0);
            else if (r == 6) press(4'b0100, 3'd0);
            else if (r == 7) press(4'b1000, 3'd0);
            else if (r == 8) set_ready(1'($urandom_range(0, 1)));
            else press(4'($urandom_range(1, 15)), 3'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 20 && snap_q.size() > 0; i++) @(posedge clk);
        chk("snapshots_drained", snap_q.size(), 0);
        chk("commits_drained", commit_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
